// File: rtl/pulse_rate_detector_pkg.sv
// rtl/pulse_rate_detector_pkg.sv - shared states, select codes and interval decode for the rate detector
package pulse_rate_detector_pkg;

  // Detector state; shared with the divider side for common tooling
  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } prd_state_t;

  typedef logic [1:0] sel_code_t;

  // Divider select encodings
  localparam sel_code_t SEL_DIV3 = 2'b00;
  localparam sel_code_t SEL_DIV2 = 2'b01;
  localparam sel_code_t SEL_DIV4 = 2'b10;
  localparam sel_code_t SEL_DIV8 = 2'b11;

  typedef struct packed {
    logic      valid;
    sel_code_t code;
  } sel_decode_t;

  // Map an edge-to-edge interval back to the divider select code.
  // Unknown intervals report invalid with code SEL_DIV3 (00).
  function automatic sel_decode_t decode_interval(input logic [31:0] interval);
    sel_decode_t d;
    d.valid = 1'b1;
    d.code  = SEL_DIV3;
    case (interval)
      32'd2:   d.code  = SEL_DIV2;
      32'd3:   d.code  = SEL_DIV3;
      32'd4:   d.code  = SEL_DIV4;
      32'd8:   d.code  = SEL_DIV8;
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pulse_rate_detector_if.sv
// rtl/pulse_rate_detector_if.sv - pulse input and measurement outputs of the rate detector
interface pulse_rate_detector_if #(
  parameter int CNT_W = 5
);
  import pulse_rate_detector_pkg::*;

  logic             pulse_in;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  sel_code_t        sel_code;
  logic             sel_valid;
  logic             timeout;

  // Stream source / result consumer
  modport master (
    output pulse_in,
    input  period,
    input  period_valid,
    input  locked,
    input  sel_code,
    input  sel_valid,
    input  timeout
  );

  // Detector side
  modport slave (
    input  pulse_in,
    output period,
    output period_valid,
    output locked,
    output sel_code,
    output sel_valid,
    output timeout
  );

endinterface

// File: rtl/pulse_rate_detector_edge_interval_counter.sv
// rtl/pulse_rate_detector_edge_interval_counter.sv - rising-edge detect and saturating interval count
module edge_interval_counter #(
  parameter int CNT_W      = 5,
  parameter int MAX_PERIOD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  output logic             edge_det,
  output logic [CNT_W-1:0] interval,
  output logic             expired
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PERIOD);

  logic             prev_in;
  logic [CNT_W-1:0] cnt;

  // cnt holds the number of cycles since the last edge, so in an edge
  // cycle it already equals the edge-to-edge interval.
  assign edge_det = pulse_in & ~prev_in;
  assign interval = cnt;
  assign expired  = (cnt == MAX_CNT);

  // Delay the input for edge detection; restart or saturate the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_in <= 1'b0;
      cnt     <= '0;
    end else begin
      prev_in <= pulse_in;
      if (edge_det) begin
        cnt <= CNT_W'(1);
      end else if (cnt != MAX_CNT) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pulse_rate_detector.sv
// rtl/pulse_rate_detector.sv - measures pulse interval, locks on a stable rate, decodes divider select
module pulse_rate_detector
  import pulse_rate_detector_pkg::*;
#(
  parameter int CNT_W      = 5,
  parameter int MAX_PERIOD = 16,
  parameter int LOCK_COUNT = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  pulse_rate_detector_if.slave prd
);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam logic [MATCH_W-1:0] LOCK_MATCHES = MATCH_W'(LOCK_COUNT);

  logic             edge_det;
  logic [CNT_W-1:0] interval;
  logic             expired;

  prd_state_t       state, state_nxt;
  logic [MATCH_W-1:0] match_cnt, match_nxt, match_inc;
  logic [CNT_W-1:0] period_q, period_nxt;
  logic             pv_q, pv_nxt;
  logic             locked_q, locked_nxt;
  sel_code_t        sel_code_q, sel_code_nxt;
  logic             sel_valid_q, sel_valid_nxt;
  logic             timeout_q, timeout_nxt;
  logic             same;
  logic             do_timeout;
  sel_decode_t      dec;

  edge_interval_counter #(
    .CNT_W      (CNT_W),
    .MAX_PERIOD (MAX_PERIOD)
  ) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse_in (prd.pulse_in),
    .edge_det (edge_det),
    .interval (interval),
    .expired  (expired)
  );

  // The previous interval is simply the published period; it reads 0 after
  // reset or timeout, which never matches a real interval (minimum 2).
  assign same      = (interval == period_q);
  assign match_inc = match_cnt + MATCH_W'(1);
  // An edge in the expiry cycle wins and is measured as MAX_PERIOD.
  assign do_timeout = (state != SEARCH) && !edge_det && expired;

  // Next state, match tracking and next values of all registered outputs
  always_comb begin
    state_nxt     = state;
    match_nxt     = match_cnt;
    period_nxt    = period_q;
    pv_nxt        = 1'b0;
    timeout_nxt   = 1'b0;
    locked_nxt    = locked_q;
    sel_code_nxt  = sel_code_q;
    sel_valid_nxt = sel_valid_q;
    dec           = decode_interval(32'(interval));

    if (do_timeout) begin
      state_nxt     = SEARCH;
      timeout_nxt   = 1'b1;
      period_nxt    = '0;
      match_nxt     = '0;
      locked_nxt    = 1'b0;
      sel_code_nxt  = SEL_DIV3;
      sel_valid_nxt = 1'b0;
    end else if (edge_det) begin
      case (state)
        SEARCH: begin
          // First edge only starts the interval clock
          state_nxt = MEASURE;
        end
        MEASURE: begin
          period_nxt = interval;
          pv_nxt     = 1'b1;
          match_nxt  = same ? match_inc : MATCH_W'(1);
          if (same && (match_inc >= LOCK_MATCHES)) begin
            state_nxt     = LOCKED;
            locked_nxt    = 1'b1;
            sel_code_nxt  = dec.code;
            sel_valid_nxt = dec.valid;
          end
        end
        LOCKED: begin
          period_nxt = interval;
          pv_nxt     = 1'b1;
          if (!same) begin
            state_nxt     = MEASURE;
            match_nxt     = MATCH_W'(1);
            locked_nxt    = 1'b0;
            sel_code_nxt  = SEL_DIV3;
            sel_valid_nxt = 1'b0;
          end
        end
        default: begin
          state_nxt = SEARCH;
          match_nxt = '0;
        end
      endcase
    end
  end

  // State, match count and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SEARCH;
      match_cnt   <= '0;
      period_q    <= '0;
      pv_q        <= 1'b0;
      locked_q    <= 1'b0;
      sel_code_q  <= SEL_DIV3;
      sel_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state       <= state_nxt;
      match_cnt   <= match_nxt;
      period_q    <= period_nxt;
      pv_q        <= pv_nxt;
      locked_q    <= locked_nxt;
      sel_code_q  <= sel_code_nxt;
      sel_valid_q <= sel_valid_nxt;
      timeout_q   <= timeout_nxt;
    end
  end

  assign prd.period       = period_q;
  assign prd.period_valid = pv_q;
  assign prd.locked       = locked_q;
  assign prd.sel_code     = sel_code_q;
  assign prd.sel_valid    = sel_valid_q;
  assign prd.timeout      = timeout_q;

endmodule

// File: tb/tb_pulse_rate_detector.sv
// tb/tb_pulse_rate_detector.sv - self-checking bench for pulse_rate_detector
module tb_pulse_rate_detector;

  localparam int CNT_W  = 5;
  localparam int MAX_P  = 16;
  localparam int LOCK_N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pulse_rate_detector_if #(.CNT_W(CNT_W)) pif();

  pulse_rate_detector #(
    .CNT_W      (CNT_W),
    .MAX_PERIOD (MAX_P),
    .LOCK_COUNT (LOCK_N)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .prd   (pif.slave)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: edge times and run length of equal intervals
  int         t;
  int         last_edge;
  int         run;
  bit         armed;
  logic       mp;
  int         e_period;
  logic       e_pv, e_locked, e_sel_valid, e_timeout;
  logic [1:0] e_sel_code;

  int to_seen;
  int pv_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    armed       = 1'b0;
    mp          = 1'b0;
    run         = 0;
    last_edge   = 0;
    e_period    = 0;
    e_pv        = 1'b0;
    e_locked    = 1'b0;
    e_sel_valid = 1'b0;
    e_sel_code  = 2'b00;
    e_timeout   = 1'b0;
  endtask

  task automatic model_step(input logic v);
    int gap;
    bit rise;
    rise      = (v === 1'b1) && (mp === 1'b0);
    gap       = t - last_edge;
    e_pv      = 1'b0;
    e_timeout = 1'b0;
    if (rise) begin
      if (armed) begin
        e_pv     = 1'b1;
        run      = (gap == e_period) ? run + 1 : 1;
        e_period = gap;
      end
      armed     = 1'b1;
      last_edge = t;
    end else if (armed && gap >= MAX_P) begin
      e_timeout = 1'b1;
      armed     = 1'b0;
      run       = 0;
      e_period  = 0;
    end
    e_locked    = (run >= LOCK_N);
    e_sel_valid = 1'b0;
    e_sel_code  = 2'b00;
    if (e_locked) begin
      case (e_period)
        2: begin e_sel_code = 2'b01; e_sel_valid = 1'b1; end
        3: begin e_sel_code = 2'b00; e_sel_valid = 1'b1; end
        4: begin e_sel_code = 2'b10; e_sel_valid = 1'b1; end
        8: begin e_sel_code = 2'b11; e_sel_valid = 1'b1; end
        default: ;
      endcase
    end
    mp = v;
    t++;
  endtask

  task automatic cycle(input logic v);
    pif.pulse_in = v;
    model_step(v);
    @(posedge clk);
    #1;
    check("period", 32'(pif.period), e_period);
    check("period_valid", 32'(pif.period_valid), 32'(e_pv));
    check("locked", 32'(pif.locked), 32'(e_locked));
    check("sel_code", 32'(pif.sel_code), 32'(e_sel_code));
    check("sel_valid", 32'(pif.sel_valid), 32'(e_sel_valid));
    check("timeout", 32'(pif.timeout), 32'(e_timeout));
    if (pif.timeout === 1'b1) to_seen++;
    if (pif.period_valid === 1'b1) pv_seen++;
  endtask

  // n pulses of the given period with a random high time
  task automatic run_stream(input int per, input int n);
    for (int e = 0; e < n; e++) begin
      int h;
      h = $urandom_range(1, per - 1);
      for (int i = 0; i < h; i++) cycle(1'b1);
      for (int i = 0; i < per - h; i++) cycle(1'b0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_period"}, 32'(pif.period), 0);
    check({tag, "_pv"}, 32'(pif.period_valid), 0);
    check({tag, "_locked"}, 32'(pif.locked), 0);
    check({tag, "_sel_code"}, 32'(pif.sel_code), 0);
    check({tag, "_sel_valid"}, 32'(pif.sel_valid), 0);
    check({tag, "_timeout"}, 32'(pif.timeout), 0);
  endtask

  initial begin
    int pick;
    int per;
    t = 0;
    to_seen = 0;
    pv_seen = 0;
    pif.pulse_in = 1'b0;
    model_reset();

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    #2 rst_n = 1'b1;

    // 1/2 stream locks after the 4th edge
    run_stream(2, 4);
    check("div2_locked", 32'(pif.locked), 1);
    check("div2_sel_code", 32'(pif.sel_code), 32'h1);
    check("div2_sel_valid", 32'(pif.sel_valid), 1);
    check("div2_period", 32'(pif.period), 2);

    // 1/4 then switch to 1/8
    run_stream(4, 5);
    check("div4_sel_code", 32'(pif.sel_code), 32'h2);
    run_stream(8, 2);
    check("div8_unlock_locked", 32'(pif.locked), 0);
    check("div8_unlock_sel_valid", 32'(pif.sel_valid), 0);
    check("div8_unlock_period", 32'(pif.period), 8);
    run_stream(8, 2);
    check("div8_locked", 32'(pif.locked), 1);
    check("div8_sel_code", 32'(pif.sel_code), 32'h3);

    // 1/3 stream
    run_stream(3, 5);
    check("div3_sel_code", 32'(pif.sel_code), 32'h0);
    check("div3_sel_valid", 32'(pif.sel_valid), 1);
    check("div3_period", 32'(pif.period), 3);

    // Interval 5: locked but no valid select
    run_stream(5, 5);
    check("p5_locked", 32'(pif.locked), 1);
    check("p5_sel_valid", 32'(pif.sel_valid), 0);
    check("p5_sel_code", 32'(pif.sel_code), 0);

    // Hold low after lock: single timeout strobe
    to_seen = 0;
    repeat (20) cycle(1'b0);
    check("hold_low_timeouts", to_seen, 1);
    check("hold_low_locked", 32'(pif.locked), 0);
    check("hold_low_period", 32'(pif.period), 0);

    // First edge after timeout only re-arms
    pv_seen = 0;
    run_stream(2, 1);
    check("rearm_no_pv", pv_seen, 0);

    // Edge exactly at MAX_PERIOD wins over timeout
    to_seen = 0;
    run_stream(16, 2);
    check("max_edge_timeouts", to_seen, 0);
    check("max_edge_period", 32'(pif.period), 16);

    // Input held high: no further edges, timeout fires
    to_seen = 0;
    repeat (20) cycle(1'b1);
    cycle(1'b0);
    check("hold_high_timeouts", to_seen, 1);
    check("hold_high_locked", 32'(pif.locked), 0);

    // Random mix of rates
    repeat (12) begin
      pick = $urandom_range(0, 5);
      case (pick)
        0: per = 2;
        1: per = 3;
        2: per = 4;
        3: per = 8;
        4: per = 5;
        default: per = $urandom_range(2, 17);
      endcase
      run_stream(per, $urandom_range(1, 6));
    end

    // Asynchronous reset while locked
    run_stream(2, 4);
    check("pre_reset_locked", 32'(pif.locked), 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    pif.pulse_in = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    pv_seen = 0;
    run_stream(2, 1);
    check("post_reset_no_pv", pv_seen, 0);
    run_stream(3, 4);
    check("post_reset_relock", 32'(pif.locked), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
